// File: rtl/cr_kme_fifo_rd_serializer.sv
// Pops one DATA_SIZE word from a FIFO and presents it downstream as NBEATS
// BEAT_SIZE beats, least-significant beat first, with no bubble between words.
module cr_kme_fifo_rd_serializer #(
   parameter int          DATA_SIZE      = 128,
   parameter int          BEAT_SIZE      = 32,
   // Reset value of words_sent; left at zero except to exercise saturation.
   parameter logic [15:0] WORDS_SENT_RST = 16'h0000,
   localparam int         NBEATS         = DATA_SIZE / BEAT_SIZE,
   localparam int         IDX_W          = $clog2(NBEATS)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DATA_SIZE-1:0] fifo_out,
   input  logic                 fifo_out_valid,
   output logic                 fifo_out_ack,
   input  logic                 clear,
   output logic [BEAT_SIZE-1:0] beat_data,
   output logic                 beat_valid,
   input  logic                 beat_ready,
   output logic                 beat_last,
   output logic [IDX_W-1:0]     beat_idx,
   output logic [15:0]          words_sent
);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } state_t;

   // Handshake: a beat transfers on a rising edge where beat_valid and
   // beat_ready are both 1; beat_valid never drops before its beat transfers
   // except on clear or rst, and the beat fields stay stable while stalled.

   state_t               r_state;
   logic [DATA_SIZE-1:0] r_hold;
   logic [IDX_W-1:0]     r_idx;
   logic [15:0]          r_words_sent;

   state_t               w_state_nxt;
   logic [IDX_W-1:0]     w_idx_nxt;
   logic                 w_accept;
   logic                 w_last_accept;
   logic                 w_word_done;

   assign beat_valid = (r_state == ST_SEND);
   assign beat_last  = beat_valid & (r_idx == IDX_W'(NBEATS - 1));
   assign beat_idx   = r_idx;
   assign words_sent = r_words_sent;

   always_comb begin
      beat_data = '0;
      for (int b = 0; b < NBEATS; b++) begin
         if (r_idx == IDX_W'(b)) begin
            beat_data = r_hold[b*BEAT_SIZE +: BEAT_SIZE];
         end
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_idx_nxt     = r_idx;
      w_accept      = beat_valid & beat_ready;
      w_last_accept = w_accept & beat_last;
      w_word_done   = w_last_accept & ~clear;
      // Popping on the last-beat handshake is what makes streaming bubble-free.
      fifo_out_ack  = fifo_out_valid & ~rst & ~clear &
                      ((r_state == ST_IDLE) | w_last_accept);

      if (clear) begin
         w_state_nxt = ST_IDLE;
         w_idx_nxt   = '0;
      end else if (fifo_out_ack) begin
         w_state_nxt = ST_SEND;
         w_idx_nxt   = '0;
      end else if (w_last_accept) begin
         w_state_nxt = ST_IDLE;
         w_idx_nxt   = '0;
      end else if (w_accept) begin
         w_idx_nxt   = r_idx + IDX_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_idx        <= '0;
         r_hold       <= '0;
         r_words_sent <= WORDS_SENT_RST;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
         if (fifo_out_ack) begin
            r_hold <= fifo_out;
         end
         if (w_word_done && (r_words_sent != 16'hFFFF)) begin
            r_words_sent <= r_words_sent + 16'd1;
         end
      end
   end

endmodule
